grid_tx: RTL and testbench
==========================

GRID_TX -- requirements
Module: grid_tx

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning the number of grid rows per frame (fixed at 8 for the 8x8 board).
REQ-002 SHALL have parameter COLS, default 8, meaning bits per row; grid width is ROWS*COLS = 64.
REQ-003 clk  input  1  single system clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 grid  input  64  current board state from the evolve register; row r occupies bits [8r+7:8r].
REQ-006 start  input  1  request to transmit one frame (snapshot of grid).
REQ-007 abort  input  1  cancel any frame in progress.
REQ-008 ready  input  1  downstream accepts row_data this cycle.
REQ-009 valid  output  1  row_data/row_idx hold a valid row.
REQ-010 row_data  output  8  current row bits.
REQ-011 row_idx  output  3  index of current row, 0..7.
REQ-012 sof  output  1  high with valid when row_idx = 0.
REQ-013 eof  output  1  high with valid when row_idx = 7.
REQ-014 busy  output  1  high in SEND or DONE.
REQ-015 done  output  1  one-cycle pulse after the last row is accepted.
REQ-016 frame_count  output  8  number of completed frames, wraps modulo 256.

Function
REQ-017 SHALL implement states IDLE, SEND, DONE; all state, snapshot and counters are flops on clk.
REQ-018 In IDLE with start=1 and abort=0, SHALL capture grid into a 64-bit snapshot, clear row_idx to 0 and enter SEND on the same edge.
REQ-019 valid SHALL be high in SEND only, first asserted the cycle after start is sampled (latency 1).
REQ-020 row_data SHALL equal snapshot[8*row_idx+7 : 8*row_idx] whenever valid=1; grid changes after capture SHALL NOT affect the frame.
REQ-021 A row transfer SHALL occur on a rising edge where valid=1 and ready=1; row_idx then increments by 1.
REQ-022 While valid=1 and ready=0, row_data, row_idx, sof and eof SHALL hold stable.
REQ-023 Transfer with row_idx = 7 SHALL move to DONE, keeping row_idx at 7 (no wrap into a second pass).
REQ-024 DONE SHALL last exactly one cycle with done=1, increment frame_count (255 -> 0), then return to IDLE.
REQ-025 start SHALL be ignored outside IDLE; start held high continuously SHALL begin a new frame in every IDLE cycle (back-to-back frames separated by DONE and one IDLE cycle).
REQ-026 abort=1 in SEND or DONE SHALL force IDLE on the next edge, with no done pulse and frame_count unchanged; abort has priority over ready and over the DONE increment.
REQ-027 abort=1 and start=1 together in IDLE SHALL leave the block in IDLE.
REQ-028 sof, eof, valid and done SHALL be low in IDLE; row_data SHALL be 0 when valid=0.

Reset
REQ-029 reset=1 SHALL immediately and asynchronously force state IDLE, snapshot 0, row_idx 0, frame_count 0, and valid, sof, eof, busy, done all 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a new start.

Verification
REQ-031 grid=64'h8040201008040201, start pulse, ready=1 constantly -> rows 01,02,04,08,10,20,40,80 on 8 consecutive cycles, sof with row 0, eof with row 7, done pulse on the next cycle, frame_count=1.
REQ-032 Same frame with ready toggled 1,0,0,1,... -> each row held stable during ready=0, order unchanged, exactly 8 transfers.
REQ-033 Change grid to 64'hFFFF_FFFF_FFFF_FFFF after start -> transmitted rows still match the captured 64'h8040201008040201.
REQ-034 abort asserted after 3 transfers -> IDLE next cycle, no done pulse, frame_count unchanged; a subsequent start sends a full frame from row 0.
REQ-035 start held high for 256 frames -> frame_count wraps to 0; start pulses during SEND are ignored (no extra frames).
REQ-036 reset asserted while row_idx=4 -> all outputs 0 immediately; after release, valid stays 0 until start.

Source files
------------

// File: rtl/grid_tx.sv
// grid_tx: transmits a snapshot of an 8x8 board as a row-per-beat stream.
//
// A start request in IDLE captures the 64-bit grid into a snapshot.
// The block then presents one row per beat under a valid/ready handshake,
// pulses done for one cycle and counts completed frames.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   grid         current board, row r in bits [COLS*r +: COLS]
//   start        request one frame (accepted in IDLE only)
//   abort        drop the frame in progress, return to IDLE
//   ready        downstream accepts row_data this cycle
//   valid        row_data/row_idx carry a row (SEND state)
//   row_data     bits of the current row, 0 when valid is low
//   row_idx      index of the current row
//   sof, eof     valid row is the first / last of the frame
//   busy         frame in SEND or DONE
//   done         one-cycle pulse after the last row is accepted
//   frame_count  completed frames, modulo 256
module grid_tx #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROWS*COLS-1:0]     grid,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     ready,
  output logic                     valid,
  output logic [COLS-1:0]          row_data,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     sof,
  output logic                     eof,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               frame_count
);

  localparam int IDX_W = $clog2(ROWS);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ROWS*COLS-1:0]  r_snap;
  logic [IDX_W-1:0]      r_row_idx;
  logic [7:0]            r_frame_count;
  logic                  w_start_ok;
  logic                  w_xfer;
  logic                  w_last_row;

  assign w_start_ok = start && !abort;
  assign w_last_row = (r_row_idx == LAST_ROW);
  // A beat moves only in SEND, and abort wins over the handshake.
  assign w_xfer     = (r_state == S_SEND) && ready && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    valid       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    sof         = 1'b0;
    eof         = 1'b0;
    row_data    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        valid    = 1'b1;
        busy     = 1'b1;
        sof      = (r_row_idx == '0);
        eof      = w_last_row;
        row_data = r_snap[int'(r_row_idx) * COLS +: COLS];
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (ready && w_last_row) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        // An abort landing in DONE cancels the completion as well.
        done        = !abort;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap        <= '0;
      r_row_idx     <= '0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_snap    <= grid;
            r_row_idx <= '0;
          end
        end
        S_SEND: begin
          // The last row stays at LAST_ROW; DONE follows instead of a wrap.
          if (w_xfer && !w_last_row) begin
            r_row_idx <= r_row_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (!abort) begin
            r_frame_count <= r_frame_count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign row_idx     = r_row_idx;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_grid_tx.sv
module tb_grid_tx;

  logic        clk;
  logic        reset;
  logic [63:0] grid;
  logic        start;
  logic        abort;
  logic        ready;
  logic        valid;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        sof;
  logic        eof;
  logic        busy;
  logic        done;
  logic [7:0]  frame_count;

  grid_tx #(.ROWS(8), .COLS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .grid        (grid),
    .start       (start),
    .abort       (abort),
    .ready       (ready),
    .valid       (valid),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .sof         (sof),
    .eof         (eof),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] idx;
    logic       sof;
    logic       eof;
  } exp_t;

  typedef logic [7:0] rows_t [8];

  exp_t       sb_q[$];
  logic [7:0] dq[$];
  int         n_cmp;
  int         n_err;
  int         done_seen;
  logic [7:0] exp_fc;

  localparam logic [63:0] G_DIAG = 64'h8040201008040201;
  localparam logic [63:0] G_TWO  = 64'h0123456789ABCDEF;
  localparam logic [63:0] G_THR  = 64'hF0E1D2C3B4A59687;

  rows_t rows_diag;
  rows_t rows_two;
  rows_t rows_thr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue the first n rows of a frame and, for complete frames, the done event.
  task automatic push_frame(input rows_t rows, input int n);
    exp_t e;
    for (int r = 0; r < n; r++) begin
      e.d   = rows[r];
      e.idx = 3'(r);
      e.sof = (r == 0);
      e.eof = (r == 7);
      sb_q.push_back(e);
    end
    if (n == 8) begin
      dq.push_back(exp_fc);
      exp_fc = exp_fc + 8'd1;
    end
  endtask

  task automatic send_start(input logic [63:0] g);
    grid  = g;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while ((busy !== 1'b0 || sb_q.size() != 0) && k < max) begin
      cyc();
      k++;
    end
    chk("idle_reached", 64'(k < max), 64'd1);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_valid"}, 64'(valid), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_sof_eof"}, 64'({sof, eof}), 64'd0);
    chk({nm, "_row_data"}, 64'(row_data), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and every done pulse.
  initial begin : monitor
    logic       hold_pend;
    logic [7:0] hold_d;
    logic [2:0] hold_idx;
    logic       hold_sof;
    logic       hold_eof;
    logic       prev_eof_xfer;
    exp_t       e;
    hold_pend     = 1'b0;
    prev_eof_xfer = 1'b0;
    hold_d        = '0;
    hold_idx      = '0;
    hold_sof      = 1'b0;
    hold_eof      = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        hold_pend     = 1'b0;
        prev_eof_xfer = 1'b0;
      end else begin
        if (hold_pend && valid === 1'b1) begin
          chk("hold_row_data", 64'(row_data), 64'(hold_d));
          chk("hold_row_idx", 64'(row_idx), 64'(hold_idx));
          chk("hold_sof_eof", 64'({sof, eof}), 64'({hold_sof, hold_eof}));
        end
        if (valid === 1'b1 && ready === 1'b1 && abort === 1'b0) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_row: got row %h idx %0d expected no beat at %0t",
                     row_data, row_idx, $time);
          end else begin
            e = sb_q.pop_front();
            chk("row_data", 64'(row_data), 64'(e.d));
            chk("row_idx", 64'(row_idx), 64'(e.idx));
            chk("sof", 64'(sof), 64'(e.sof));
            chk("eof", 64'(eof), 64'(e.eof));
          end
        end
        if (done === 1'b1) begin
          done_seen++;
          chk("done_after_last_row", 64'(prev_eof_xfer), 64'd1);
          if (dq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
          end else begin
            chk("frame_count_at_done", 64'(frame_count), 64'(dq.pop_front()));
          end
        end
        hold_pend     = (valid === 1'b1) && (ready === 1'b0) && (abort === 1'b0);
        hold_d        = row_data;
        hold_idx      = row_idx;
        hold_sof      = sof;
        hold_eof      = eof;
        prev_eof_xfer = (valid === 1'b1) && (ready === 1'b1) && (abort === 1'b0) && (eof === 1'b1);
      end
    end
  end

  initial begin : stim
    int k;
    int target;
    n_cmp     = 0;
    n_err     = 0;
    done_seen = 0;
    exp_fc    = 8'd0;
    rows_diag = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rows_two  = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    rows_thr  = '{8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};

    reset = 1'b1;
    grid  = 64'd0;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b0;
    #1;
    chk_quiet("reset");
    chk("reset_row_idx", 64'(row_idx), 64'd0);
    chk("reset_frame_count", 64'(frame_count), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk_quiet("after_reset");

    // Diagonal frame, ready always high.
    ready = 1'b1;
    push_frame(rows_diag, 8);
    send_start(G_DIAG);
    chk("first_beat_valid", 64'(valid), 64'd1);
    wait_idle(40);
    chk("fc_after_frame1", 64'(frame_count), 64'd1);

    // Same frame with ready toggling 0,0,1,...
    push_frame(rows_diag, 8);
    ready = 1'b1;
    send_start(G_DIAG);
    k = 1;
    while ((busy === 1'b1 || sb_q.size() != 0) && k < 60) begin
      ready = (k % 3 == 0);
      cyc();
      k++;
    end
    ready = 1'b1;
    wait_idle(20);
    chk("fc_after_frame2", 64'(frame_count), 64'd2);

    // Grid overwritten after capture.
    push_frame(rows_diag, 8);
    ready = 1'b0;
    send_start(G_DIAG);
    grid = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    cyc();
    ready = 1'b1;
    wait_idle(40);
    chk("fc_after_frame3", 64'(frame_count), 64'd3);

    // Abort after three transfers.
    push_frame(rows_diag, 3);
    ready = 1'b1;
    send_start(G_DIAG);
    k = 0;
    while (row_idx !== 3'd3 && k < 20) begin
      cyc();
      k++;
    end
    chk("abort_reach_row3", 64'(k < 20), 64'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_quiet("after_abort");
    chk("fc_after_abort", 64'(frame_count), 64'd3);
    push_frame(rows_two, 8);
    send_start(G_TWO);
    chk("restart_row_idx", 64'(row_idx), 64'd0);
    wait_idle(40);
    chk("fc_after_restart", 64'(frame_count), 64'd4);

    // start pulses during SEND are ignored.
    push_frame(rows_two, 8);
    ready = 1'b0;
    send_start(G_TWO);
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      cyc();
    end
    start = 1'b0;
    ready = 1'b1;
    wait_idle(40);
    cyc();
    cyc();
    chk_quiet("no_extra_frame");
    chk("fc_after_pulses", 64'(frame_count), 64'd5);

    // abort together with start in IDLE.
    abort = 1'b1;
    start = 1'b1;
    grid  = G_THR;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    chk_quiet("abort_start_idle");

    // Reset while row_idx = 4.
    push_frame(rows_diag, 4);
    ready = 1'b1;
    send_start(G_DIAG);
    k = 0;
    while (row_idx !== 3'd4 && k < 20) begin
      cyc();
      k++;
    end
    chk("reset_reach_row4", 64'(k < 20), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_quiet("midframe_reset");
    chk("midframe_reset_row_idx", 64'(row_idx), 64'd0);
    chk("midframe_reset_fc", 64'(frame_count), 64'd0);
    sb_q.delete();
    exp_fc = 8'd0;
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_reset_valid", 64'(valid), 64'd0);
    end

    // 256 back-to-back frames with start held high.
    for (int f = 0; f < 256; f++) begin
      push_frame(rows_thr, 8);
    end
    target = done_seen + 256;
    grid   = G_THR;
    start  = 1'b1;
    k = 0;
    while (done_seen < target && k < 4000) begin
      cyc();
      k++;
    end
    start = 1'b0;
    chk("frames256_done", 64'(k < 4000), 64'd1);
    wait_idle(30);
    chk("fc_wrapped", 64'(frame_count), 64'd0);

    chk("rows_left", 64'(sb_q.size()), 64'd0);
    chk("dones_left", 64'(dq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
